// File: rtl/shift_arbiter.sv
// Purpose: two-requester valid/ready arbiter sharing one 16-bit right barrel shifter,
//          with a single-entry registered result stage.
// Latency: request accepted at edge N, result visible right after edge N; 1 result/cycle.
// Backpressure: result stage full and res_ready low -> no request accepted, outputs hold.
// Ports: clk/rst_n; req0_*/req1_* valid, ready, diff[4:0], data[15:0];
//        res_valid/res_ready/res_data/res_src; busy_cnt = saturating stall counter.
// Optional: define SHIFT_ARB_STICKY_EN to add res_sticky (OR of shifted-out bits).

module barrel_shifter_r (
  input  logic [15:0] num,
  input  logic [4:0]  diff,
  output logic [15:0] shifted_num
);
  logic [15:0] s1, s2, s4, s8;

  // Log shifter: one stage per diff bit; diff[4] alone clears everything.
  assign s1 = diff[0] ? {1'b0,  num[15:1]} : num;
  assign s2 = diff[1] ? {2'b0,  s1[15:2]}  : s1;
  assign s4 = diff[2] ? {4'b0,  s2[15:4]}  : s2;
  assign s8 = diff[3] ? {8'b0,  s4[15:8]}  : s4;
  assign shifted_num = diff[4] ? 16'h0000 : s8;
endmodule

module shift_arbiter #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_diff,
  input  logic [15:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_diff,
  input  logic [15:0] req1_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_src,
  output logic [7:0]  busy_cnt
`ifdef SHIFT_ARB_STICKY_EN
  ,
  output logic        res_sticky
`endif
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t      state;
  logic        last_grant;
  logic        can_accept;
  logic        win_sel;
  logic        accept;
  logic [4:0]  sel_diff;
  logic [15:0] sel_data;
  logic [15:0] shifted;

  assign res_valid  = (state == FULL);
  assign can_accept = (state == EMPTY) | res_ready;

  always_comb begin
    win_sel = 1'b0;
    if (req0_valid && req1_valid)
      win_sel = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
    else if (req1_valid)
      win_sel = 1'b1;
  end

  // rst_n gates ready so nothing appears accepted while reset is held.
  assign req0_ready = rst_n & can_accept & req0_valid & ~win_sel;
  assign req1_ready = rst_n & can_accept & req1_valid &  win_sel;
  assign accept     = req0_ready | req1_ready;

  assign sel_diff = win_sel ? req1_diff : req0_diff;
  assign sel_data = win_sel ? req1_data : req0_data;

  barrel_shifter_r u_shifter (
    .num         (sel_data),
    .diff        (sel_diff),
    .shifted_num (shifted)
  );

`ifdef SHIFT_ARB_STICKY_EN
  logic [15:0] lost_mask;
  logic        sticky_nxt;

  // Mask of the bits that fall off the right end; computed beside the shifter.
  assign lost_mask  = sel_diff[4] ? 16'hFFFF : ((16'd1 << sel_diff[3:0]) - 16'd1);
  assign sticky_nxt = |(sel_data & lost_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      res_sticky <= 1'b0;
    else if (accept)
      res_sticky <= sticky_nxt;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      res_data   <= 16'h0000;
      res_src    <= 1'b0;
      last_grant <= 1'b1;
      busy_cnt   <= 8'd0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state      <= FULL;
            res_data   <= shifted;
            res_src    <= win_sel;
            last_grant <= win_sel;
          end
        end
        FULL: begin
          // Back-to-back replace when consumer drains and a new request arrives.
          if (accept) begin
            res_data   <= shifted;
            res_src    <= win_sel;
            last_grant <= win_sel;
          end else if (res_ready) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
      if ((req0_valid || req1_valid) && !can_accept && busy_cnt != 8'hFF)
        busy_cnt <= busy_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        v0, v1, rr;
  logic [4:0]  d0, d1;
  logic [15:0] x0, x1;
  logic [1:0]  r0, r1, rv, rs;
  logic [15:0] rd [2];
  logic [7:0]  bc [2];
`ifdef SHIFT_ARB_STICKY_EN
  logic [1:0]  st;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state, index 0 = round-robin unit, 1 = fixed-priority unit.
  bit          mv [2];
  logic [15:0] md [2];
  bit          ms [2];
  bit          ml [2];
  int          mb [2];
  bit          mst[2];

  always #5 clk = ~clk;

  shift_arbiter #(.FIXED_PRIO(0)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(r0[0]), .req0_diff(d0), .req0_data(x0),
    .req1_valid(v1), .req1_ready(r1[0]), .req1_diff(d1), .req1_data(x1),
    .res_valid(rv[0]), .res_ready(rr), .res_data(rd[0]), .res_src(rs[0]),
    .busy_cnt(bc[0])
`ifdef SHIFT_ARB_STICKY_EN
    , .res_sticky(st[0])
`endif
  );

  shift_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(r0[1]), .req0_diff(d0), .req0_data(x0),
    .req1_valid(v1), .req1_ready(r1[1]), .req1_diff(d1), .req1_data(x1),
    .res_valid(rv[1]), .res_ready(rr), .res_data(rd[1]), .res_src(rs[1]),
    .busy_cnt(bc[1])
`ifdef SHIFT_ARB_STICKY_EN
    , .res_sticky(st[1])
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] m_shift(input logic [15:0] d, input int s);
    if (s >= 16) return 16'h0000;
    return d / (16'd1 << s);
  endfunction

  function automatic bit m_sticky(input logic [15:0] d, input int s);
    if (s == 0) return 1'b0;
    if (s >= 16) return d != 0;
    return (d % (32'd1 << s)) != 0;
  endfunction

  // Compare process: on every falling edge, check the registered outputs and the
  // combinational readies against the model, then advance the model one cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        bit can, w, e0, e1;
        if (!rst_n) begin
          mv[i] = 0; md[i] = 0; ms[i] = 0; ml[i] = 1; mb[i] = 0; mst[i] = 0;
        end
        chk($sformatf("u%0d.res_valid", i), rv[i], mv[i]);
        chk($sformatf("u%0d.res_data", i),  rd[i], md[i]);
        chk($sformatf("u%0d.res_src", i),   rs[i], ms[i]);
        chk($sformatf("u%0d.busy_cnt", i),  bc[i], mb[i]);
`ifdef SHIFT_ARB_STICKY_EN
        chk($sformatf("u%0d.res_sticky", i), st[i], mst[i]);
`endif
        can = !mv[i] || rr;
        if (v0 && v1) w = (i == 1) ? 1'b0 : !ml[i];
        else          w = v1;
        e0 = rst_n && can && v0 && !w;
        e1 = rst_n && can && v1 && w;
        chk($sformatf("u%0d.req0_ready", i), r0[i], e0);
        chk($sformatf("u%0d.req1_ready", i), r1[i], e1);
        if (rst_n) begin
          if ((v0 || v1) && !can && mb[i] < 255) mb[i]++;
          if (e0 || e1) begin
            mv[i]  = 1;
            md[i]  = w ? m_shift(x1, d1) : m_shift(x0, d0);
            mst[i] = w ? m_sticky(x1, d1) : m_sticky(x0, d0);
            ms[i]  = w;
            ml[i]  = w;
          end else if (rr) begin
            mv[i] = 0;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; v0 = 0; v1 = 0; rr = 1;
    d0 = 0; d1 = 0; x0 = 0; x1 = 0;
    cyc(); cyc();
    rst_n = 1;
    chk("reset res_valid", rv, 2'b00);
    chk("reset busy_cnt", bc[0], 8'd0);
    chk("reset res_data", rd[0], 16'h0000);

    // Conflict: rr unit alternates 0,1,0,1; fp unit always grants req0.
    v0 = 1; d0 = 5'd1;  x0 = 16'h0003;
    v1 = 1; d1 = 5'd17; x1 = 16'hFFFF;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr req0_ready", r0[0], (k % 2 == 0) ? 1 : 0);
      chk("fp req1_ready", r1[1], 1'b0);
      cyc();
      chk("rr conflict src", rs[0], (k % 2 == 0) ? 0 : 1);
      chk("rr conflict data", rd[0], (k % 2 == 0) ? 16'h0001 : 16'h0000);
      chk("fp conflict src", rs[1], 1'b0);
      chk("fp conflict data", rd[1], 16'h0001);
`ifdef SHIFT_ARB_STICKY_EN
      chk("rr conflict sticky", st[0], 1'b1);
`endif
    end

    // Single request from req0.
    v1 = 0; d0 = 5'd4; x0 = 16'hF0F0;
    cyc();
    chk("single valid", rv, 2'b11);
    chk("single data", rd[0], 16'h0F0F);
    chk("single src", rs[0], 1'b0);
`ifdef SHIFT_ARB_STICKY_EN
    chk("single sticky", st[0], 1'b0);
`endif
    v0 = 0;
    cyc();
    chk("drain to empty", rv, 2'b00);

    // Backpressure: fill with pass-through, then stall req1 for 5 cycles.
    rr = 0; v0 = 1; d0 = 5'd0; x0 = 16'h1234;
    cyc();
    chk("fill data", rd[0], 16'h1234);
    v0 = 0; v1 = 1; d1 = 5'd15; x1 = 16'h8000;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall req1_ready", r1[0], 1'b0);
      cyc();
    end
    chk("stall busy_cnt", bc[0], 8'd5);
    chk("stall data held", rd[0], 16'h1234);
    rr = 1;
    #1;
    chk("release req1_ready", r1[0], 1'b1);
    cyc();
    chk("release src", rs[0], 1'b1);
    chk("release data", rd[0], 16'h0001);

    // Saturation: 300 more stalled cycles with req1 pending.
    rr = 0;
    repeat (300) cyc();
    chk("sat busy_cnt rr", bc[0], 8'd255);
    chk("sat busy_cnt fp", bc[1], 8'd255);

    // Asynchronous reset mid-operation.
    chk("pre-reset valid", rv, 2'b11);
    rst_n = 0;
    #1;
    chk("async reset valid", rv, 2'b00);
    chk("async reset ready", r1, 2'b00);
    cyc();
    rst_n = 1;
    v0 = 1; d0 = 5'd1; x0 = 16'h0003; rr = 1;
    #1;
    chk("post-reset req0_ready", r0[0], 1'b1);
    chk("post-reset req1_ready", r1[0], 1'b0);
    cyc();
    chk("post-reset src", rs[0], 1'b0);
    chk("post-reset data", rd[0], 16'h0001);

    v0 = 0; v1 = 0;
    cyc(); cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
